// File: rtl/pri_pkg.sv
// Shared definitions for the priority encoder / grant decoder pair.
package pri_pkg;

   // Default code width, shared with priority_enc.
   localparam int unsigned W_DEF = 2;

   // Grant decoder FSM states.
   typedef enum logic [1:0] {
      S_IDLE,
      S_GRANT,
      S_REL
   } pri_dec_state_t;

endpackage

// File: rtl/pri_pend_buf.sv
// One-entry pending code buffer with a sticky overflow flag.
module pri_pend_buf #(
   parameter int unsigned W = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] push_code,
   input  logic         pop,
   output logic         pend_v,
   output logic [W-1:0] pend_code,
   output logic         ovf
);

   // A push in the same cycle as a pop refills the slot; a push into a full slot is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_v    <= 1'b0;
         pend_code <= '0;
         ovf       <= 1'b0;
      end else begin
         if (push && pend_v && !pop) begin
            ovf <= 1'b1;
         end
         if (push && (!pend_v || pop)) begin
            pend_v    <= 1'b1;
            pend_code <= push_code;
         end else if (pop) begin
            pend_v <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/priority_dec_grant.sv
// Registered W:2^W decoder with grant/ack handshake, hold timeout and a pending slot.
module priority_dec_grant
   import pri_pkg::*;
#(
   parameter int unsigned W        = W_DEF,
   parameter int unsigned HOLD_MAX = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 p,
   input  logic [W-1:0]         code,
   input  logic                 ack,
   output logic [(1 << W)-1:0]  grant,
   output logic                 gvalid,
   output logic                 busy,
   output logic                 timeout,
   output logic                 ovf
);

   localparam int unsigned N        = 1 << W;
   localparam int unsigned CW       = $clog2(HOLD_MAX + 1);
   localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_MAX);

   pri_dec_state_t state;
   logic [CW-1:0]  hold_cnt;
   logic           pend_v;
   logic [W-1:0]   pend_code;
   logic           push;
   logic           pop;

   function automatic logic [N-1:0] dec(input logic [W-1:0] c);
      dec = N'(1) << c;
   endfunction

   // p is buffered unless IDLE with an empty slot takes it straight into a grant.
   // The slot is drained whenever the FSM is free to start a grant (IDLE or REL).
   always_comb begin
      push = p && !((state == S_IDLE) && !pend_v);
      pop  = pend_v && (state != S_GRANT);
   end

   pri_pend_buf #(
      .W (W)
   ) u_pend (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_code (code),
      .pop       (pop),
      .pend_v    (pend_v),
      .pend_code (pend_code),
      .ovf       (ovf)
   );

   // FSM, one-hot decode and hold counter; grant and timeout are registered.
   // REL always spends one cycle with grant low; a waiting pending code is granted
   // directly from REL so it lands two cycles after the releasing ack.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         grant    <= '0;
         hold_cnt <= '0;
         timeout  <= 1'b0;
      end else begin
         timeout <= 1'b0;
         case (state)
            S_IDLE: begin
               if (pend_v) begin
                  grant    <= dec(pend_code);
                  hold_cnt <= CW'(1);
                  state    <= S_GRANT;
               end else if (p) begin
                  grant    <= dec(code);
                  hold_cnt <= CW'(1);
                  state    <= S_GRANT;
               end
            end
            S_GRANT: begin
               if (ack) begin
                  grant    <= '0;
                  hold_cnt <= '0;
                  state    <= S_REL;
               end else if (hold_cnt == HOLD_LIM) begin
                  grant    <= '0;
                  hold_cnt <= '0;
                  timeout  <= 1'b1;
                  state    <= S_REL;
               end else begin
                  hold_cnt <= hold_cnt + CW'(1);
               end
            end
            S_REL: begin
               if (pend_v) begin
                  grant    <= dec(pend_code);
                  hold_cnt <= CW'(1);
                  state    <= S_GRANT;
               end else begin
                  state <= S_IDLE;
               end
            end
            default: begin
               grant    <= '0;
               hold_cnt <= '0;
               state    <= S_IDLE;
            end
         endcase
      end
   end

   // Status outputs derived from registered state.
   always_comb begin
      gvalid = |grant;
      busy   = (state != S_IDLE) || pend_v;
   end

endmodule
